// File: rtl/regfile_mp.sv
// Multi-port integer register file: NREAD combinational reads, two clocked writes, x0 = 0,
// and a per-register pending scoreboard. Define RF_BYPASS_EN for write-to-read forwarding.
module regfile_mp #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned NREGS = 32,
    parameter int unsigned NREAD = 2,
    localparam int unsigned AW   = $clog2(NREGS)
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [NREAD*AW-1:0]   RADDR,
    output logic [NREAD*XLEN-1:0] RDAT,
    output logic [NREAD-1:0]      RPEND,
    input  logic                  WrEn0,
    input  logic                  WrEn1,
    input  logic [AW-1:0]         Rw0,
    input  logic [AW-1:0]         Rw1,
    input  logic [XLEN-1:0]       busW0,
    input  logic [XLEN-1:0]       busW1,
    input  logic                  IssEn,
    input  logic [AW-1:0]         IssRd,
    output logic [NREGS-1:0]      PendMask
);

    logic [NREGS-1:0][XLEN-1:0] regs_q, regs_d;
    logic [NREGS-1:0]           pend_q, pend_d;

    // Port 1 is applied after port 0 so it wins a same-register conflict; issue is applied
    // after the write clears so a same-cycle issue stays outstanding.
    always_comb begin
        regs_d = regs_q;
        pend_d = pend_q;
        if (WrEn0) begin
            regs_d[Rw0] = busW0;
            pend_d[Rw0] = 1'b0;
        end
        if (WrEn1) begin
            regs_d[Rw1] = busW1;
            pend_d[Rw1] = 1'b0;
        end
        if (IssEn) begin
            pend_d[IssRd] = 1'b1;
        end
        regs_d[0] = '0;
        pend_d[0] = 1'b0;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            regs_q <= '0;
            pend_q <= '0;
        end else begin
            regs_q <= regs_d;
            pend_q <= pend_d;
        end
    end

    assign PendMask = {pend_q[NREGS-1:1], 1'b0};

    for (genvar i = 0; i < int'(NREAD); i++) begin : g_rd
        logic [AW-1:0]   ra;
        logic [XLEN-1:0] rd;
        logic            rp;

        assign ra = RADDR[i*AW +: AW];

`ifdef RF_BYPASS_EN
        logic iss_hit;
        assign iss_hit = IssEn && (IssRd == ra);

        always_comb begin
            rd = regs_q[ra];
            rp = pend_q[ra];
            if (ra == '0) begin
                rd = '0;
                rp = 1'b0;
            end else if (!RST) begin
                if (WrEn1 && (Rw1 == ra)) begin
                    rd = busW1;
                    rp = iss_hit ? pend_q[ra] : 1'b0;
                end else if (WrEn0 && (Rw0 == ra)) begin
                    rd = busW0;
                    rp = iss_hit ? pend_q[ra] : 1'b0;
                end
            end
        end
`else
        always_comb begin
            rd = regs_q[ra];
            rp = pend_q[ra];
            if (ra == '0) begin
                rd = '0;
                rp = 1'b0;
            end
        end
`endif

        assign RDAT[i*XLEN +: XLEN] = rd;
        assign RPEND[i]             = rp;
    end

endmodule

// File: tb/tb_regfile_mp.sv
// Self-checking bench for regfile_mp: spec-level array model compared every cycle, plus
// directed literal checks; a second 4-port 64-bit instance covers wide multi-port reads.
module tb_regfile_mp;

    localparam int XLEN  = 32;
    localparam int NREGS = 32;
    localparam int NREAD = 2;
    localparam int AW    = 5;
`ifdef RF_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic                  CLK = 1'b0;
    logic                  RST;
    logic [NREAD*AW-1:0]   RADDR;
    logic [NREAD*XLEN-1:0] RDAT;
    logic [NREAD-1:0]      RPEND;
    logic                  WrEn0, WrEn1, IssEn;
    logic [AW-1:0]         Rw0, Rw1, IssRd;
    logic [XLEN-1:0]       busW0, busW1;
    logic [NREGS-1:0]      PendMask;

    // Wide instance: NREAD=4, XLEN=64, NREGS=16
    logic [15:0]  raddr4;
    logic [255:0] rdat4;
    logic [3:0]   rpend4;
    logic         we0_4, we1_4, iss4;
    logic [3:0]   rw0_4, rw1_4, issrd4;
    logic [63:0]  bw0_4, bw1_4;
    logic [15:0]  pm4;

    int n_cmp = 0;
    int n_err = 0;
    bit chk_en = 1'b0;

    logic [XLEN-1:0] mregs [NREGS];
    logic            mpend [NREGS];

    always #5 CLK = ~CLK;

    regfile_mp #(.XLEN(XLEN), .NREGS(NREGS), .NREAD(NREAD)) dut (
        .CLK(CLK), .RST(RST), .RADDR(RADDR), .RDAT(RDAT), .RPEND(RPEND),
        .WrEn0(WrEn0), .WrEn1(WrEn1), .Rw0(Rw0), .Rw1(Rw1), .busW0(busW0), .busW1(busW1),
        .IssEn(IssEn), .IssRd(IssRd), .PendMask(PendMask)
    );

    regfile_mp #(.XLEN(64), .NREGS(16), .NREAD(4)) dut4 (
        .CLK(CLK), .RST(RST), .RADDR(raddr4), .RDAT(rdat4), .RPEND(rpend4),
        .WrEn0(we0_4), .WrEn1(we1_4), .Rw0(rw0_4), .Rw1(rw1_4), .busW0(bw0_4), .busW1(bw1_4),
        .IssEn(iss4), .IssRd(issrd4), .PendMask(pm4)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model state update on each rising edge, straight from the operation rules
    initial forever begin
        @(posedge CLK);
        if (RST) begin
            for (int r = 0; r < NREGS; r++) begin
                mregs[r] = '0;
                mpend[r] = 1'b0;
            end
        end else begin
            for (int r = 1; r < NREGS; r++) begin
                if (IssEn && IssRd == r) mpend[r] = 1'b1;
                else if ((WrEn0 && Rw0 == r) || (WrEn1 && Rw1 == r)) mpend[r] = 1'b0;
            end
            if (WrEn0 && Rw0 != 0) mregs[Rw0] = busW0;
            if (WrEn1 && Rw1 != 0) mregs[Rw1] = busW1;
        end
    end

    function automatic logic [XLEN-1:0] exp_rd(input logic [AW-1:0] a);
        if (a == 0) return '0;
        if (BYP && !RST && WrEn1 && Rw1 == a) return busW1;
        if (BYP && !RST && WrEn0 && Rw0 == a) return busW0;
        return mregs[a];
    endfunction

    function automatic logic exp_pend(input logic [AW-1:0] a);
        bit wr_hit;
        if (a == 0) return 1'b0;
        wr_hit = (WrEn1 && Rw1 == a) || (WrEn0 && Rw0 == a);
        if (BYP && !RST && wr_hit && !(IssEn && IssRd == a)) return 1'b0;
        return mpend[a];
    endfunction

    function automatic logic [NREGS-1:0] exp_mask();
        logic [NREGS-1:0] m;
        for (int r = 0; r < NREGS; r++) m[r] = mpend[r];
        return m;
    endfunction

    // Per-cycle compare, mid-cycle after inputs settle
    initial forever begin
        @(negedge CLK);
        #2;
        if (chk_en) begin
            for (int i = 0; i < NREAD; i++) begin
                logic [AW-1:0] a;
                a = RADDR[i*AW +: AW];
                check($sformatf("rdat%0d[r%0d]", i, a), 64'(RDAT[i*XLEN +: XLEN]), 64'(exp_rd(a)));
                check($sformatf("rpend%0d[r%0d]", i, a), 64'(RPEND[i]), 64'(exp_pend(a)));
            end
            check("pendmask", 64'(PendMask), 64'(exp_mask()));
        end
    end

    task automatic idle();
        WrEn0 = 1'b0; WrEn1 = 1'b0; IssEn = 1'b0;
        Rw0 = '0; Rw1 = '0; IssRd = '0; busW0 = '0; busW1 = '0;
    endtask

    task automatic set_rd(input logic [AW-1:0] a0, input logic [AW-1:0] a1);
        RADDR = {a1, a0};
    endtask

    initial begin
        RST = 1'b1;
        idle();
        set_rd(0, 0);
        raddr4 = '0; we0_4 = 1'b0; we1_4 = 1'b0; iss4 = 1'b0;
        rw0_4 = '0; rw1_4 = '0; issrd4 = '0; bw0_4 = '0; bw1_4 = '0;
        repeat (2) @(negedge CLK);
        RST = 1'b0;
        chk_en = 1'b1;
        set_rd(5, 0);
        #3;
        check("reset_rdat", 64'(RDAT[31:0]), 64'h0);
        check("reset_mask", 64'(PendMask), 64'h0);

        // Fill all registers; issue every odd register in the same cycle it is written
        for (int r = 1; r < NREGS; r += 2) begin
            @(negedge CLK);
            WrEn0 = 1'b1; Rw0 = AW'(r);     busW0 = 32'h1000_0000 + 32'(r) * 32'h0101_0101;
            WrEn1 = (r < 31); Rw1 = AW'(r + 1); busW1 = 32'h1000_0000 + 32'(r + 1) * 32'h0101_0101;
            IssEn = 1'b1; IssRd = AW'(r);
            set_rd(AW'(r), AW'(r + 1));
        end
        @(negedge CLK);
        idle();
        set_rd(10, 31);
        #3;
        check("fill_r10", 64'(RDAT[31:0]), 64'h1A0A_0A0A);
        check("fill_r31", 64'(RDAT[63:32]), 64'h2F1F_1F1F);
        check("fill_mask", 64'(PendMask), 64'hAAAA_AAAA);
        for (int a = 0; a < NREGS; a += 2) begin
            @(negedge CLK);
            set_rd(AW'(a), AW'(a + 1));
        end

        // Reset with a write held: target stays 0, pending discarded
        @(negedge CLK);
        RST = 1'b1;
        WrEn0 = 1'b1; Rw0 = 9; busW0 = 32'hFFFF_0009;
        set_rd(9, 0);
        @(negedge CLK);
        RST = 1'b0;
        idle();
        #3;
        check("rst_r9", 64'(RDAT[31:0]), 64'h0);
        check("rst_mask", 64'(PendMask), 64'h0);
        for (int a = 0; a < NREGS; a += 2) begin
            @(negedge CLK);
            set_rd(AW'(a), AW'(a + 1));
        end

        // x0 write and issue are dropped
        @(negedge CLK);
        WrEn0 = 1'b1; Rw0 = 0; busW0 = 32'hDEAD_BEEF;
        IssEn = 1'b1; IssRd = 0;
        set_rd(0, 0);
        @(negedge CLK);
        idle();
        #3;
        check("x0_rdat", 64'(RDAT[31:0]), 64'h0);
        check("x0_mask", 64'(PendMask), 64'h0);

        // Dual-write conflict: port 1 wins
        @(negedge CLK);
        WrEn0 = 1'b1; Rw0 = 5; busW0 = 32'h1111_1111;
        WrEn1 = 1'b1; Rw1 = 5; busW1 = 32'h2222_2222;
        set_rd(5, 5);
        @(negedge CLK);
        idle();
        #3;
        check("dual_r5", 64'(RDAT[31:0]), 64'h2222_2222);

        // Scoreboard on reg 7
        @(negedge CLK);
        IssEn = 1'b1; IssRd = 7;
        set_rd(7, 7);
        @(negedge CLK);
        idle();
        #3;
        check("sb_issue", 64'(RPEND[0]), 64'h1);
        @(negedge CLK);
        @(negedge CLK);
        WrEn0 = 1'b1; Rw0 = 7; busW0 = 32'h7777_7777;
        #3;
        check("sb_wr_same", 64'(RPEND[0]), BYP ? 64'h0 : 64'h1);
        @(negedge CLK);
        idle();
        #3;
        check("sb_wr_next", 64'(RPEND[0]), 64'h0);
        check("sb_wr_data", 64'(RDAT[31:0]), 64'h7777_7777);
        @(negedge CLK);
        IssEn = 1'b1; IssRd = 7;
        WrEn1 = 1'b1; Rw1 = 7; busW1 = 32'h7070_7070;
        #3;
        check("sb_iss_wr_same", 64'(RPEND[0]), 64'h0);
        @(negedge CLK);
        idle();
        #3;
        check("sb_iss_wr_next", 64'(RPEND[0]), 64'h1);
        @(negedge CLK);
        IssEn = 1'b1; IssRd = 7;
        @(negedge CLK);
        idle();
        #3;
        check("sb_reissue", 64'(PendMask), 64'h0000_0080);

        // Write to a non-pending register
        @(negedge CLK);
        WrEn0 = 1'b1; Rw0 = 8; busW0 = 32'h0000_8888;
        set_rd(8, 7);
        @(negedge CLK);
        idle();
        #3;
        check("nonpend_bit", 64'(RPEND[0]), 64'h0);
        check("nonpend_data", 64'(RDAT[31:0]), 64'h0000_8888);

        // Write-to-read forwarding on port 1
        @(negedge CLK);
        WrEn0 = 1'b1; Rw0 = 3; busW0 = 32'h3333_3333;
        set_rd(0, 4);
        @(negedge CLK);
        idle();
        WrEn1 = 1'b1; Rw1 = 3; busW1 = 32'hA5A5_A5A5;
        set_rd(0, 3);
        #3;
        check("byp_same", 64'(RDAT[63:32]), BYP ? 64'hA5A5_A5A5 : 64'h3333_3333);
        @(negedge CLK);
        idle();
        #3;
        check("byp_next", 64'(RDAT[63:32]), 64'hA5A5_A5A5);

        // Wide instance: four distinct registers read in one cycle
        @(negedge CLK);
        we0_4 = 1'b1; rw0_4 = 2;  bw0_4 = 64'h0202_0202_0202_0202;
        we1_4 = 1'b1; rw1_4 = 11; bw1_4 = 64'hB0B1_B2B3_B4B5_B6B7;
        @(negedge CLK);
        rw0_4 = 13; bw0_4 = 64'hD000_0000_0000_000D;
        rw1_4 = 15; bw1_4 = 64'hFFFF_0000_FFFF_0000;
        @(negedge CLK);
        we0_4 = 1'b0; we1_4 = 1'b0;
        raddr4 = {4'd15, 4'd13, 4'd11, 4'd2};
        #3;
        check("mp_port0", rdat4[63:0],    64'h0202_0202_0202_0202);
        check("mp_port1", rdat4[127:64],  64'hB0B1_B2B3_B4B5_B6B7);
        check("mp_port2", rdat4[191:128], 64'hD000_0000_0000_000D);
        check("mp_port3", rdat4[255:192], 64'hFFFF_0000_FFFF_0000);
        check("mp_rpend", 64'(rpend4), 64'h0);

        @(negedge CLK);
        chk_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/regfile_mp.md
# regfile_mp

Parametrised multi-port integer register file for the RISC-V core, replacing the single-write, two-read register array. It provides NREAD combinational read ports and two clocked write ports, with x0 hardwired to zero and full synchronous clear. An issue-tracking scoreboard holds one pending bit per register so decode can stall on read-after-write hazards. Instantiated between decode (reads, issue) and writeback (writes).

## Interface
- XLEN, 32, register width in bits
- NREGS, 32, register count; power of two, ≥ 2; AW = $clog2(NREGS) is derived, not a parameter
- NREAD, 2, number of read ports, 1..4

- CLK  in  1  clock; all state updates on rising edge
- RST  in  1  reset, synchronous, active-high
- RADDR  in  NREAD*AW  read addresses; port i = RADDR[i*AW +: AW]
- RDAT  out  NREAD*XLEN  read data; port i = RDAT[i*XLEN +: XLEN]
- RPEND  out  NREAD  pending bit of the register addressed by port i
- WrEn0, WrEn1  in  1  write enables
- Rw0, Rw1  in  AW  write addresses
- busW0, busW1  in  XLEN  write data
- IssEn  in  1  issue strobe; marks IssRd as pending
- IssRd  in  AW  destination of issuing instruction
- PendMask  out  NREGS  all pending bits, bit r = register r

## Operation
- Storage: NREGS x XLEN array plus NREGS pending bits. Register 0 reads 0 at all times; writes and issues to address 0 are dropped; PendMask[0] is always 0.
- Writes: on rising CLK, reg[Rw0] <= busW0 if WrEn0; reg[Rw1] <= busW1 if WrEn1. Both ports targeting the same register: port 1 wins.
- Reads: RDAT[i] = reg[RADDR_i], combinational; there is no read enable.
- Scoreboard, per register r ≠ 0, on rising CLK:
  - set if IssEn && IssRd == r
  - else clear if (WrEn0 && Rw0 == r) || (WrEn1 && Rw1 == r)
  - Set and clear on the same register in the same cycle: set wins, since the new issue is outstanding.
  - A write to a non-pending register is legal, updates data, and leaves the bit at 0.
  - Re-issuing an already-pending register keeps it at 1. There is no count.
- RPEND[i] = pend[RADDR_i]. PendMask = pend vector, registered.
- Reset: when RST = 1 at a rising edge, all registers become 0 and all pending bits become 0. RST overrides any write or issue in that cycle. Reset mid-operation discards all outstanding pending state.

## Timing
- Write latency: data written at edge N is visible on RDAT from edge N onward, i.e. the cycle after write-enable is asserted. Same-cycle visibility requires RF_BYPASS_EN.
- Issue-to-pending: IssEn at cycle N gives RPEND/PendMask = 1 from cycle N+1.
- Write-to-clear: a write in cycle N clears pending from cycle N+1. With RF_BYPASS_EN, RPEND drops in cycle N.
- Reset values: RDAT = 0 for every port, RPEND = 0, PendMask = 0, from the edge on which RST is sampled high.
- All outputs are combinational from RADDR and state, plus the write ports when bypass is enabled. There are no output registers.

## Configuration
- RF_BYPASS_EN defined: write-to-read forwarding.
  - RDAT[i] returns busW1 if WrEn1 && Rw1 == RADDR_i != 0, else busW0 if WrEn0 && Rw0 == RADDR_i != 0, else the array value.
  - RPEND[i] is masked to 0 by the same qualifying write, unless IssEn && IssRd == RADDR_i in that cycle.
  - Forwarding is suppressed while RST = 1.
- RF_BYPASS_EN undefined: reads and RPEND reflect registered state only. This adds one cycle of read-after-write latency. PendMask is unaffected in both builds.

## Test plan
- Reset: write random values to all registers, then pulse RST for 1 cycle → every RDAT = 0, PendMask = 0; a WrEn0 held during RST leaves its target at 0.
- x0: WrEn0 = 1, Rw0 = 0, busW0 = 0xDEADBEEF; IssEn with IssRd = 0 → RDAT for RADDR = 0 stays 0 and PendMask[0] = 0.
- Dual-write conflict: WrEn0/WrEn1 both to reg 5 with 0x11111111 / 0x22222222 → next cycle reg 5 reads 0x22222222.
- Scoreboard: issue reg 7 at cycle 1 → RPEND = 1 from cycle 2. Write reg 7 at cycle 4 → RPEND = 0 at cycle 5, or at cycle 4 with bypass. Issue plus write to reg 7 in the same cycle → stays 1.
- Bypass (RF_BYPASS_EN): WrEn1, Rw1 = 3, busW1 = 0xA5A5A5A5 with RADDR port 1 = 3 → RDAT port 1 = 0xA5A5A5A5 in the same cycle. The non-bypass build returns the old value in that cycle and the new value in the next.
- Multi-port (NREAD = 4, XLEN = 64, NREGS = 16): all four ports read distinct registers in one cycle → each port returns its own 64-bit value. An address ≥ 16 is impossible because AW = 4.
